// File: rtl/scope_trace_render.sv
// Triggered multi-channel sample capture into ping-pong buffers, rendered as
// coloured traces over a graticule on a VGA pixel stream with a 2-cycle pipeline.
module scope_trace_render #(
    parameter int unsigned N_CH         = 2,
    parameter int unsigned SAMPLE_W     = 8,
    parameter int unsigned DEPTH        = 640,
    parameter int unsigned Y_BASE       = 112,
    parameter int unsigned AUTO_TIMEOUT = 65535
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_sample_valid,
    input  logic [N_CH*SAMPLE_W-1:0]   i_sample,
    input  logic [SAMPLE_W-1:0]        i_trig_level,
    input  logic [1:0]                 i_trig_mode,
    input  logic                       i_arm,
    input  logic [3:0]                 i_decim,
    input  logic                       i_grid_en,
    input  logic [9:0]                 i_coord_x,
    input  logic [9:0]                 i_coord_y,
    input  logic                       i_visible,
    input  logic                       i_h_sync,
    input  logic                       i_v_sync,
    output logic [3:0]                 o_r,
    output logic [3:0]                 o_g,
    output logic [3:0]                 o_b,
    output logic                       o_h_sync,
    output logic                       o_v_sync,
    output logic [1:0]                 o_state,
    output logic                       o_frame_valid
);

    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned DW   = N_CH * SAMPLE_W;
    localparam int unsigned MAXV = (1 << SAMPLE_W) - 1;

    typedef enum logic [1:0] {
        StArmed   = 2'd0,
        StCapture = 2'd1,
        StDone    = 2'd2,
        StIdle    = 2'd3
    } state_e;

    state_e              r_state;
    logic                r_front;
    logic                r_frame_valid;
    logic [SAMPLE_W-1:0] r_prev;
    logic                r_prev_ok;
    logic [31:0]         r_auto_cnt;
    logic [3:0]          r_dec_cnt;
    logic [3:0]          r_decim_l;
    logic [1:0]          r_mode_l;
    logic [AW-1:0]       r_wr_idx;

    logic [SAMPLE_W-1:0] w_ch0;
    logic                w_edge;
    logic                w_force;
    logic                w_trig;
    logic                w_cap_wr;
    logic                w_last;
    logic                w_we;
    logic [AW-1:0]       w_waddr;
    logic                w_at_origin;

    assign w_ch0       = i_sample[SAMPLE_W-1:0];
    assign w_edge      = r_prev_ok && (r_prev < i_trig_level) && (w_ch0 >= i_trig_level);
    assign w_force     = (i_trig_mode == 2'd0) && (r_auto_cnt >= 32'(AUTO_TIMEOUT));
    assign w_trig      = i_sample_valid && (r_state == StArmed) && (w_edge || w_force);
    assign w_cap_wr    = i_sample_valid && (r_state == StCapture) && (r_dec_cnt == r_decim_l);
    assign w_last      = (r_wr_idx == AW'(DEPTH - 1));
    assign w_we        = w_trig || w_cap_wr;
    assign w_waddr     = w_trig ? '0 : r_wr_idx;
    assign w_at_origin = (i_coord_x == 10'd0) && (i_coord_y == 10'd0);

    // Mode and decimation are sampled live while armed and frozen at the trigger.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= StArmed;
            r_front       <= 1'b0;
            r_frame_valid <= 1'b0;
            r_prev        <= '0;
            r_prev_ok     <= 1'b0;
            r_auto_cnt    <= '0;
            r_dec_cnt     <= '0;
            r_decim_l     <= '0;
            r_mode_l      <= '0;
            r_wr_idx      <= '0;
        end else begin
            if (i_sample_valid) begin
                r_prev    <= w_ch0;
                r_prev_ok <= 1'b1;
            end
            case (r_state)
                StArmed: begin
                    if (w_trig) begin
                        r_state    <= StCapture;
                        r_wr_idx   <= AW'(1);
                        r_dec_cnt  <= '0;
                        r_mode_l   <= i_trig_mode;
                        r_decim_l  <= i_decim;
                        r_auto_cnt <= '0;
                    end else if (i_sample_valid && (r_auto_cnt != '1)) begin
                        r_auto_cnt <= r_auto_cnt + 32'd1;
                    end
                end
                StCapture: begin
                    if (i_sample_valid) begin
                        if (r_dec_cnt == r_decim_l) begin
                            r_dec_cnt <= '0;
                            if (w_last) begin
                                r_state <= StDone;
                            end else begin
                                r_wr_idx <= r_wr_idx + AW'(1);
                            end
                        end else begin
                            r_dec_cnt <= r_dec_cnt + 4'd1;
                        end
                    end
                end
                StDone: begin
                    if (w_at_origin) begin
                        r_front       <= ~r_front;
                        r_frame_valid <= 1'b1;
                        r_auto_cnt    <= '0;
                        r_state       <= (r_mode_l == 2'd2) ? StIdle : StArmed;
                    end
                end
                StIdle: begin
                    if (i_arm) begin
                        r_state    <= StArmed;
                        r_auto_cnt <= '0;
                    end
                end
                default: r_state <= StArmed;
            endcase
        end
    end

    assign o_state       = r_state;
    assign o_frame_valid = r_frame_valid;

    logic [DW-1:0] r_mem0 [DEPTH];
    logic [DW-1:0] r_mem1 [DEPTH];
    logic [DW-1:0] r_rd_data;
    logic          w_rd_en;
    logic [AW-1:0] w_raddr;

    assign w_rd_en = (32'(i_coord_x) < DEPTH);
    assign w_raddr = AW'(i_coord_x);

    // Capture always writes the back buffer; render reads the front one.
    always_ff @(posedge i_clk) begin
        if (w_we && r_front) begin
            r_mem0[w_waddr] <= i_sample;
        end
        if (w_we && !r_front) begin
            r_mem1[w_waddr] <= i_sample;
        end
        if (w_rd_en) begin
            r_rd_data <= r_front ? r_mem1[w_raddr] : r_mem0[w_raddr];
        end
    end

    logic [5:0] r_x1_lo;
    logic [9:0] r_y1;
    logic       r_xin1;
    logic       r_vis1;
    logic       r_hs1;
    logic       r_vs1;
    logic       r_grid1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_x1_lo <= '0;
            r_y1    <= '0;
            r_xin1  <= 1'b0;
            r_vis1  <= 1'b0;
            r_hs1   <= 1'b1;
            r_vs1   <= 1'b1;
            r_grid1 <= 1'b0;
        end else begin
            r_x1_lo <= i_coord_x[5:0];
            r_y1    <= i_coord_y;
            r_xin1  <= w_rd_en;
            r_vis1  <= i_visible;
            r_hs1   <= i_h_sync;
            r_vs1   <= i_v_sync;
            r_grid1 <= i_grid_en;
        end
    end

    logic [N_CH-1:0] w_lit;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [10:0] w_target;
        assign w_target = 11'(Y_BASE + MAXV) - 11'(r_rd_data[c*SAMPLE_W +: SAMPLE_W]);
        assign w_lit[c] = r_xin1 && r_frame_valid && ({1'b0, r_y1} == w_target);
    end

    function automatic logic [11:0] ch_colour(input int c);
        case (c)
            0:       return 12'h0F0;
            1:       return 12'hFF0;
            2:       return 12'h0FF;
            default: return 12'hF0F;
        endcase
    endfunction

    logic [11:0] w_rgb;

    // Channels scanned high to low so the lowest lit channel ends up on top.
    always_comb begin
        w_rgb = 12'h000;
        if (r_grid1 && ((r_x1_lo == 6'd0) || (r_y1[5:0] == 6'd0))) begin
            w_rgb = 12'h444;
        end
        for (int c = int'(N_CH) - 1; c >= 0; c--) begin
            if (w_lit[c]) begin
                w_rgb = ch_colour(c);
            end
        end
        if (!r_vis1) begin
            w_rgb = 12'h000;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_r      <= '0;
            o_g      <= '0;
            o_b      <= '0;
            o_h_sync <= 1'b1;
            o_v_sync <= 1'b1;
        end else begin
            o_r      <= w_rgb[11:8];
            o_g      <= w_rgb[7:4];
            o_b      <= w_rgb[3:0];
            o_h_sync <= r_hs1;
            o_v_sync <= r_vs1;
        end
    end

endmodule

// File: tb/tb_scope_trace_render.sv
// Scoreboarded bench: probe pixels are tagged by pulsing the syncs low; a monitor
// pops the expected colour whenever the delayed syncs come out low.
module tb_scope_trace_render;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_sample_valid;
    logic [15:0] i_sample;
    logic [7:0]  i_trig_level;
    logic [1:0]  i_trig_mode;
    logic        i_arm;
    logic [3:0]  i_decim;
    logic        i_grid_en;
    logic [9:0]  i_coord_x;
    logic [9:0]  i_coord_y;
    logic        i_visible;
    logic        i_h_sync;
    logic        i_v_sync;
    logic [3:0]  o_r;
    logic [3:0]  o_g;
    logic [3:0]  o_b;
    logic        o_h_sync;
    logic        o_v_sync;
    logic [1:0]  o_state;
    logic        o_frame_valid;

    scope_trace_render #(
        .N_CH        (2),
        .SAMPLE_W    (8),
        .DEPTH       (640),
        .Y_BASE      (112),
        .AUTO_TIMEOUT(16)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_sample_valid(i_sample_valid),
        .i_sample      (i_sample),
        .i_trig_level  (i_trig_level),
        .i_trig_mode   (i_trig_mode),
        .i_arm         (i_arm),
        .i_decim       (i_decim),
        .i_grid_en     (i_grid_en),
        .i_coord_x     (i_coord_x),
        .i_coord_y     (i_coord_y),
        .i_visible     (i_visible),
        .i_h_sync      (i_h_sync),
        .i_v_sync      (i_v_sync),
        .o_r           (o_r),
        .o_g           (o_g),
        .o_b           (o_b),
        .o_h_sync      (o_h_sync),
        .o_v_sync      (o_v_sync),
        .o_state       (o_state),
        .o_frame_valid (o_frame_valid)
    );

    initial forever #5 i_clk = ~i_clk;

    typedef struct {
        int          id;
        logic [11:0] rgb;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_probe = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic neutral();
        i_coord_x = 10'd700;
        i_coord_y = 10'd470;
        i_visible = 1'b0;
        i_h_sync  = 1'b1;
        i_v_sync  = 1'b1;
    endtask

    task automatic probe(input int x, input int y, input bit vis, input bit grid,
                         input logic [11:0] rgb);
        exp_t e;
        i_coord_x = 10'(x);
        i_coord_y = 10'(y);
        i_visible = vis;
        i_grid_en = grid;
        i_h_sync  = 1'b0;
        i_v_sync  = 1'b0;
        e.id      = n_probe;
        e.rgb     = rgb;
        n_probe++;
        exp_q.push_back(e);
        @(negedge i_clk);
        neutral();
    endtask

    task automatic send(input int c0, input int c1);
        i_sample       = {8'(c1), 8'(c0)};
        i_sample_valid = 1'b1;
        @(negedge i_clk);
        i_sample_valid = 1'b0;
    endtask

    task automatic swap();
        i_coord_x = 10'd0;
        i_coord_y = 10'd0;
        @(negedge i_clk);
        neutral();
    endtask

    // Monitor: any low delayed sync marks a probed pixel arriving at the outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (!i_rst && (o_h_sync === 1'b0 || o_v_sync === 1'b0)) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pixel: got sync %b%b expected none", o_h_sync,
                             o_v_sync);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("pixel%0d_rgb", e.id), {20'd0, o_r, o_g, o_b}, {20'd0, e.rgb});
                    check($sformatf("pixel%0d_sync", e.id), {30'd0, o_h_sync, o_v_sync}, 32'd0);
                end
            end
        end
    end

    initial begin
        neutral();
        i_rst          = 1'b1;
        i_sample_valid = 1'b0;
        i_sample       = '0;
        i_trig_level   = 8'd128;
        i_trig_mode    = 2'd1;
        i_arm          = 1'b0;
        i_decim        = 4'd0;
        i_grid_en      = 1'b0;
        repeat (3) @(negedge i_clk);
        check("rst_state", 32'(o_state), 0);
        check("rst_fv", 32'(o_frame_valid), 0);
        check("rst_rgb", {20'd0, o_r, o_g, o_b}, 0);
        check("rst_sync", {30'd0, o_h_sync, o_v_sync}, 3);
        i_rst = 1'b0;
        @(negedge i_clk);

        probe(5, 112, 1, 0, 12'h000);
        probe(64, 100, 1, 1, 12'h444);

        // Normal mode ramp: trigger at 128, buffer[i] = (128+i)%256, ch1 = 0.
        for (int i = 0; i < 768; i++) begin
            send(i % 256, 0);
            if (i == 127) check("ramp_armed", 32'(o_state), 0);
            if (i == 128) check("ramp_trig", 32'(o_state), 1);
            if (i == 766) check("ramp_not_done", 32'(o_state), 1);
        end
        check("ramp_done", 32'(o_state), 2);
        check("ramp_fv_pre", 32'(o_frame_valid), 0);
        probe(0, 239, 1, 0, 12'h000);
        swap();
        check("ramp_swap_state", 32'(o_state), 0);
        check("ramp_swap_fv", 32'(o_frame_valid), 1);
        probe(0, 239, 1, 0, 12'h0F0);
        probe(1, 238, 1, 0, 12'h0F0);
        probe(639, 112, 1, 0, 12'h0F0);
        probe(0, 367, 1, 0, 12'hFF0);
        probe(128, 367, 1, 0, 12'h0F0);
        probe(650, 367, 1, 1, 12'h000);
        probe(640, 367, 1, 1, 12'h444);
        probe(0, 239, 0, 0, 12'h000);
        probe(64, 100, 1, 1, 12'h444);

        // Decimate by 4, level 50, ch1 = ch0; mid-capture mode/decim edits ignored.
        i_trig_level = 8'd50;
        i_decim      = 4'd3;
        for (int j = 0; j < 2607; j++) begin
            send(j % 256, j % 256);
            if (j == 150) begin
                i_decim     = 4'd0;
                i_trig_mode = 2'd2;
            end
            if (j == 2605) check("dec_not_done", 32'(o_state), 1);
        end
        check("dec_done", 32'(o_state), 2);
        probe(0, 239, 1, 0, 12'h0F0);
        swap();
        check("dec_swap_state", 32'(o_state), 0);
        probe(0, 317, 1, 0, 12'h0F0);
        probe(1, 313, 1, 0, 12'h0F0);
        probe(2, 309, 1, 0, 12'h0F0);
        probe(1, 317, 1, 0, 12'h000);
        probe(600, 221, 1, 0, 12'h0F0);

        // Single mode: one capture, then idle until re-armed.
        i_trig_level = 8'd128;
        send(0, 0);
        check("single_armed", 32'(o_state), 0);
        send(200, 0);
        check("single_trig", 32'(o_state), 1);
        for (int k = 0; k < 639; k++) send(100, 0);
        check("single_done", 32'(o_state), 2);
        swap();
        check("single_idle", 32'(o_state), 3);
        check("single_fv", 32'(o_frame_valid), 1);
        send(0, 0);
        send(200, 0);
        check("single_ignore", 32'(o_state), 3);
        probe(0, 167, 1, 0, 12'h0F0);
        probe(1, 267, 1, 0, 12'h0F0);
        probe(1, 367, 1, 0, 12'hFF0);
        probe(2, 167, 1, 0, 12'h000);
        i_arm = 1'b1;
        @(negedge i_clk);
        i_arm = 1'b0;
        check("single_rearm", 32'(o_state), 0);

        // Reset in the middle of a capture.
        i_trig_mode = 2'd1;
        send(0, 0);
        send(200, 0);
        for (int k = 0; k < 299; k++) send(100, 0);
        check("mid_capture", 32'(o_state), 1);
        i_coord_x = 10'd0;
        i_coord_y = 10'd167;
        i_visible = 1'b1;
        i_grid_en = 1'b1;
        i_rst     = 1'b1;
        #1;
        check("mid_rst_state", 32'(o_state), 0);
        check("mid_rst_fv", 32'(o_frame_valid), 0);
        check("mid_rst_rgb", {20'd0, o_r, o_g, o_b}, 0);
        check("mid_rst_sync", {30'd0, o_h_sync, o_v_sync}, 3);
        i_trig_mode = 2'd0;
        repeat (2) @(negedge i_clk);
        check("mid_rst_rgb_hold", {20'd0, o_r, o_g, o_b}, 0);
        i_rst = 1'b0;
        neutral();
        @(negedge i_clk);
        probe(0, 317, 1, 0, 12'h000);

        // Auto mode: constant input, forced trigger after 16 valid samples.
        for (int k = 0; k < 16; k++) send(10, 250);
        check("auto_wait", 32'(o_state), 0);
        send(10, 250);
        check("auto_force", 32'(o_state), 1);
        for (int k = 0; k < 639; k++) send(10, 250);
        check("auto_done", 32'(o_state), 2);
        swap();
        check("auto_swap_state", 32'(o_state), 0);
        check("auto_swap_fv", 32'(o_frame_valid), 1);
        probe(3, 357, 1, 0, 12'h0F0);
        probe(3, 117, 1, 0, 12'hFF0);
        probe(3, 356, 1, 0, 12'h000);
        probe(3, 357, 0, 0, 12'h000);

        repeat (4) @(negedge i_clk);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/scope_trace_render.md
SCOPE_TRACE_RENDER -- requirements
Module: scope_trace_render

Interface
REQ-001 Parameter N_CH, default 2, number of traced channels, legal range 1..4.
REQ-002 Parameter SAMPLE_W, default 8, sample width in bits (unsigned).
REQ-003 Parameter DEPTH, default 640, samples per screen; equals displayed trace width in pixels.
REQ-004 Parameter Y_BASE, default 112, screen row of full-scale sample; 2^SAMPLE_W + Y_BASE <= 480 SHALL hold.
REQ-005 Parameter AUTO_TIMEOUT, default 65535, valid samples without trigger before auto mode forces one.
REQ-006 i_clk  in  1  single clock, pixel rate, all logic rising-edge.
REQ-007 i_rst  in  1  asynchronous, active-high reset.
REQ-008 i_sample_valid  in  1  qualifies i_sample this cycle.
REQ-009 i_sample  in  N_CH*SAMPLE_W  channel c occupies bits [c*SAMPLE_W +: SAMPLE_W].
REQ-010 i_trig_level  in  SAMPLE_W  trigger threshold on channel 0.
REQ-011 i_trig_mode  in  2  0 auto, 1 normal, 2 single, 3 treated as normal.
REQ-012 i_arm  in  1  one-cycle pulse re-arming single mode.
REQ-013 i_decim  in  4  store every (i_decim+1)th valid sample.
REQ-014 i_grid_en  in  1  enables graticule.
REQ-015 i_coord_x, i_coord_y  in  10 each  current pixel from VGA timing.
REQ-016 i_visible  in  1  pixel in active area; i_h_sync, i_v_sync  in  1 each  raw syncs.
REQ-017 o_r, o_g, o_b  out  4 each  pixel colour; o_h_sync, o_v_sync  out  1 each  delayed syncs.
REQ-018 o_state  out  2  capture state; o_frame_valid  out  1  a completed capture is displayed.

Function
REQ-019 Two DEPTH x (N_CH*SAMPLE_W) buffers SHALL ping-pong: capture writes back buffer, render reads front buffer.
REQ-020 States: ARMED(0), CAPTURE(1), DONE(2), IDLE(3).
- ARMED: trigger on valid sample where previous valid ch0 < i_trig_level and current ch0 >= i_trig_level -> CAPTURE.
- ARMED, mode 0: AUTO_TIMEOUT valid samples with no trigger -> forced trigger on next valid sample.
- CAPTURE: trigger sample written to index 0; decimated samples to indices 1..DEPTH-1; write of index DEPTH-1 -> DONE.
- DONE: at cycle where i_coord_x==0 and i_coord_y==0 swap buffers, set o_frame_valid=1; mode 2 -> IDLE, else -> ARMED.
- IDLE: i_arm pulse -> ARMED; i_arm ignored in other states.
REQ-021 Decimation counter SHALL restart at trigger; trigger sample always stored regardless of i_decim.
REQ-022 i_trig_mode/i_decim changes SHALL take effect on next entry to ARMED; mid-capture changes ignored.
REQ-023 Previous-sample register SHALL update on every valid sample in all states; first valid sample after reset never triggers.
REQ-024 Render pipeline latency SHALL be exactly 2 cycles: cycle 1 buffer read at address i_coord_x, cycle 2 compare and register outputs.
REQ-025 i_h_sync, i_v_sync, i_visible SHALL be delayed 2 cycles to stay aligned with colour.
REQ-026 Channel c lit when i_coord_y == Y_BASE + (2^SAMPLE_W - 1) - sample_c, x < DEPTH, o_frame_valid=1.
REQ-027 Colours: ch0 green F/0/F-less (0,F,0), ch1 (F,F,0), ch2 (0,F,F), ch3 (F,0,F); lowest lit channel wins.
REQ-028 Grid (i_grid_en, no trace lit): x%64==0 or y%64==0 -> (4,4,4); otherwise (0,0,0).
REQ-029 Delayed i_visible=0 SHALL force colour to (0,0,0).
REQ-030 i_coord_x >= DEPTH SHALL read no memory and display grid/black only.

Reset
REQ-031 i_rst SHALL immediately force state ARMED, o_frame_valid=0, front buffer index 0, counters 0, o_r/o_g/o_b=0, o_h_sync=o_v_sync=1.
REQ-032 Buffer contents are not reset; o_frame_valid=0 suppresses traces until first swap.
REQ-033 Reset mid-CAPTURE SHALL abandon the partial capture; no swap occurs.

Verification
REQ-034 Mode 1, level 128, ch0 ramp 0..255 step 1, i_decim 0 -> trigger at sample 128; buffer[0]=128, buffer[639]=(128+639)%256=255; swap at next (0,0).
REQ-035 Mode 0, ch0 constant 10, AUTO_TIMEOUT 16 -> forced capture after 16 valid samples; o_frame_valid=1 after swap.
REQ-036 Mode 2 -> one swap then o_state=IDLE; further triggers ignored until i_arm pulse, then ARMED.
REQ-037 Front sample ch0=255, ch1=255 at x=5 -> pixel (5,112) outputs (0,F,0) 2 cycles after coords, syncs delayed 2 cycles.
REQ-038 i_decim 3 -> stored samples are every 4th valid input after trigger; buffer[1]=trigger+4.
REQ-039 Assert i_rst at CAPTURE index 300 -> state ARMED, front buffer unchanged, colours 0 during reset.
